// File: rtl/yl3_pkg.sv
// Shared definitions for the YL-3 number formatter.
// Holds character codes, the overflow string, the display limit, the FSM state type
// and the double-dabble nibble-adjust helper used by the BCD converter.
package yl3_pkg;

  localparam logic [7:0]  CHR_SPACE = 8'h20;
  localparam logic [7:0]  CHR_ZERO  = 8'h30;
  localparam logic [63:0] OFLO_STR  = 64'h2020_2020_4F46_4C4F;  // "    OFLO"
  localparam logic [63:0] BLANK_STR = 64'h2020_2020_2020_2020;  // eight spaces
  localparam logic [26:0] MAX_DISP  = 27'd99_999_999;

  localparam int unsigned BinW      = 27;
  localparam logic [4:0]  LastIter  = 5'(BinW - 1);

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StFormat,
    StSend,
    StWaitAck
  } state_e;

  // Add 3 to every BCD nibble that is >= 5, so the following left shift carries correctly.
  function automatic logic [31:0] dabble_adjust(input logic [31:0] bcd);
    logic [31:0] r;
    r = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/yl3_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, fixed 27-cycle latency.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       load bin and begin conversion (takes priority over a running one)
//   bin[26:0]   unsigned binary input, sampled on start
//   busy        conversion in progress
//   done        1-cycle pulse during the final shift cycle; bcd is final from the next cycle
//   bcd[31:0]   8 BCD nibbles, [31:28] most significant
module yl3_bin2bcd_seq
  import yl3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [26:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd
);

  logic [26:0] shift_q;
  logic [31:0] bcd_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic [31:0] adj;

  assign adj = dabble_adjust(bcd_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      shift_q <= bin;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      bcd_q   <= {adj[30:0], shift_q[26]};
      shift_q <= {shift_q[25:0], 1'b0};
      cnt_q   <= cnt_q + 5'd1;
      if (cnt_q == LastIter) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Flagged one cycle early so the caller can leave its wait state on the same edge
  // that lands the last shift.
  assign done = busy_q && (cnt_q == LastIter);
  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/yl3_num_formatter.sv
// Converts a 27-bit unsigned value to an 8-character ASCII decimal string and hands it
// to the YL-3 serial display driver over its level-held load/ready handshake.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   in_value     value to display, captured when in_valid && in_ready
//   in_valid     in_value is valid
//   in_ready     high only while idle
//   disp_data    ASCII string, [63:56] leftmost character
//   disp_load    registered load request, held until the driver drops disp_ready
//   disp_ready   driver ready flag
// Parameters:
//   BLANK_ZEROS  replace leading zeros with spaces (rightmost digit always shown)
//   SKIP_SAME    suppress resending a string identical to the last one accepted
module yl3_num_formatter
  import yl3_pkg::*;
#(
  parameter bit BLANK_ZEROS = 1'b1,
  parameter bit SKIP_SAME   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [26:0] in_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] disp_data,
  input  logic        disp_ready,
  output logic        disp_load
);

  state_e      state_q, state_d;
  logic [26:0] value_q;
  logic [63:0] disp_data_q, disp_data_d;
  logic        disp_load_q, disp_load_d;
  logic [63:0] last_q, last_d;
  logic        sent_q, sent_d;

  logic        start;
  logic        bcd_busy;
  logic        bcd_done;
  logic [31:0] bcd;
  logic [63:0] fmt_str;

  assign start = (state_q == StIdle) && in_valid;

  yl3_bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (in_value),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // String builder, evaluated while in FORMAT when bcd holds the final digits.
  always_comb begin
    logic       leading;
    logic [3:0] nib;
    fmt_str = OFLO_STR;
    leading = BLANK_ZEROS;
    nib     = '0;
    if (value_q <= MAX_DISP) begin
      for (int i = 0; i < 8; i++) begin
        nib = bcd[31-4*i -: 4];
        if (leading && (nib == 4'd0) && (i < 7)) begin
          fmt_str[63-8*i -: 8] = CHR_SPACE;
        end else begin
          leading              = 1'b0;
          fmt_str[63-8*i -: 8] = CHR_ZERO + {4'h0, nib};
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    disp_data_d = disp_data_q;
    disp_load_d = disp_load_q;
    last_d      = last_q;
    sent_d      = sent_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) state_d = StConvert;
      end
      StConvert: begin
        // !bcd_busy only matters if the converter was somehow lost; avoids a hang.
        if (bcd_done || !bcd_busy) state_d = StFormat;
      end
      StFormat: begin
        disp_data_d = fmt_str;
        if (SKIP_SAME && sent_q && (fmt_str == last_q)) begin
          state_d = StIdle;
        end else begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (disp_ready) begin
          disp_load_d = 1'b1;
          state_d     = StWaitAck;
        end
      end
      StWaitAck: begin
        // Driver drops ready once it has copied the string.
        if (!disp_ready) begin
          disp_load_d = 1'b0;
          last_d      = disp_data_q;
          sent_d      = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      value_q     <= '0;
      disp_data_q <= BLANK_STR;
      disp_load_q <= 1'b0;
      last_q      <= BLANK_STR;
      sent_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_data_q <= disp_data_d;
      disp_load_q <= disp_load_d;
      last_q      <= last_d;
      sent_q      <= sent_d;
      if (start) value_q <= in_value;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign disp_data = disp_data_q;
  assign disp_load = disp_load_q;

endmodule

// File: tb/tb_yl3_num_formatter.sv
// Scoreboard bench for yl3_num_formatter. Two instances share stimulus: one blanks
// leading zeros, one does not; both skip repeated strings so their handshakes line up.
module tb_yl3_num_formatter;

  logic        clk;
  logic        rst_n;
  logic [26:0] in_value;
  logic        in_valid;
  logic        disp_ready;
  logic        in_ready, in_ready2;
  logic [63:0] disp_data, disp_data2;
  logic        disp_load, disp_load2;

  yl3_num_formatter #(.BLANK_ZEROS(1'b1), .SKIP_SAME(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .disp_data  (disp_data),
    .disp_ready (disp_ready),
    .disp_load  (disp_load)
  );

  yl3_num_formatter #(.BLANK_ZEROS(1'b0), .SKIP_SAME(1'b1)) dut_nb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .disp_data  (disp_data2),
    .disp_ready (disp_ready),
    .disp_load  (disp_load2)
  );

  typedef struct {
    logic [63:0] s_blank;
    logic [63:0] s_plain;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          drv_busy = 1'b0;
  logic [63:0] m_last;
  bit          m_flag = 1'b0;

  localparam logic [63:0] SPACES = 64'h2020_2020_2020_2020;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division, leading-zero blanking, overflow text.
  function automatic logic [63:0] model_str(input int unsigned v, input bit blank);
    logic [63:0] s;
    int unsigned div, d;
    bit          lead;
    if (v > 99_999_999) return 64'h2020_2020_4F46_4C4F;
    s    = '0;
    lead = blank;
    div  = 10_000_000;
    for (int i = 0; i < 8; i++) begin
      d = (v / div) % 10;
      if (lead && d == 0 && i < 7) s[63-8*i -: 8] = 8'h20;
      else begin
        lead = 1'b0;
        s[63-8*i -: 8] = 8'(48 + d);
      end
      div = div / 10;
    end
    return s;
  endfunction

  // Driver model: keeps ready high for two cycles of load, then drops it.
  initial begin : driver
    int hi;
    hi = 0;
    disp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && disp_load) begin
        hi++;
        if (hi >= 2) disp_ready = 1'b0;
      end else begin
        hi = 0;
        disp_ready = !drv_busy;
      end
    end
  end

  // Monitor: pops the scoreboard on each rising load and checks data, latency, hold length.
  initial begin : monitor
    bit   prev;
    int   hold;
    exp_t cur;
    prev = 1'b0;
    hold = 0;
    cur  = '{s_blank: SPACES, s_plain: SPACES, acc: 0, lat: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        hold = 0;
      end else begin
        if (disp_load && !prev) begin
          chk("load_pair", {63'b0, disp_load2}, 64'd1);
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_load: got load with data %h required no load", disp_data);
          end else begin
            cur = sb.pop_front();
            chk("data_blank", disp_data, cur.s_blank);
            chk("data_plain", disp_data2, cur.s_plain);
            if (cur.lat > 0) chk("load_latency", 64'(cyc - cur.acc), 64'(cur.lat));
          end
          hold = 1;
        end else if (disp_load) begin
          hold++;
          chk("data_stable", disp_data, cur.s_blank);
        end else if (prev) begin
          chk("load_hold_cycles", 64'(hold), 64'd2);
        end
        prev = disp_load;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("return_idle", {63'b0, in_ready}, 64'd1);
  endtask

  // Offers v; abort=1 means the transaction will be killed by reset (nothing expected).
  task automatic issue(input int unsigned v, input int lat, input int junk, input bit abort);
    logic [63:0] sb_s;
    int          acc;
    in_value = 27'(v);
    in_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    chk("accept_ready_low", {63'b0, in_ready}, 64'd0);
    if (!abort) begin
      sb_s = model_str(v, 1'b1);
      if (!(m_flag && sb_s == m_last)) begin
        sb.push_back('{s_blank: sb_s, s_plain: model_str(v, 1'b0), acc: acc, lat: lat});
        m_last = sb_s;
        m_flag = 1'b1;
      end
    end
    // Upstream keeps presenting junk while busy; none of it may be taken.
    for (int j = 0; j < junk; j++) begin
      in_value = 27'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    chk({tag, "_load"}, {63'b0, disp_load}, 64'd0);
    chk({tag, "_data"}, disp_data, SPACES);
    chk({tag, "_data_plain"}, disp_data2, SPACES);
  endtask

  initial begin : main
    int unsigned v, prev_v, r;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    m_last   = SPACES;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 29, 0, 1'b0);          wait_idle();
    issue(12_345_678, 29, 5, 1'b0); wait_idle();
    issue(99_999_999, 29, 0, 1'b0); wait_idle();
    issue(100_000_000, 29, 0, 1'b0); wait_idle();
    issue(42, 29, 10, 1'b0);        wait_idle();

    // Driver busy long after FORMAT: no load, data held.
    drv_busy = 1'b1;
    @(negedge clk);
    issue(555, 0, 0, 1'b0);
    repeat (130) @(negedge clk);
    chk("busy_no_load", {63'b0, disp_load}, 64'd0);
    chk("busy_data_held", disp_data, model_str(555, 1'b1));
    chk("busy_data_plain", disp_data2, model_str(555, 1'b0));
    chk("busy_not_ready", {63'b0, in_ready}, 64'd0);
    drv_busy = 1'b0;
    wait_idle();

    // Same value twice: second one must not load.
    issue(7, 29, 0, 1'b0); wait_idle();
    issue(7, 29, 0, 1'b0); wait_idle();

    // Reset mid-conversion aborts and clears the last-sent flag.
    issue(7, 0, 0, 1'b1);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_state("abort");
    m_flag = 1'b0;
    m_last = SPACES;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(7, 29, 0, 1'b0); wait_idle();

    prev_v = 7;
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       v = $urandom_range(0, 999);
        1:       v = $urandom_range(0, 99_999_999);
        2:       v = $urandom & 32'h07FF_FFFF;
        default: v = prev_v;
      endcase
      issue(v, 29, $urandom_range(0, 10), 1'b0);
      wait_idle();
      prev_v = v;
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
